ifu_fetch_queue: RTL and testbench

- Parametrised successor fetch unit: PC generation, in-order request/response handshake to a variable-latency instruction memory, and a FIFO fetch queue toward decode.
- Sits between PcGen-style redirect logic (branch resolution in EX) and the decode stage.
- Decouples fetch from decode stall via valid/ready backpressure.
- Discards in-flight wrong-path responses after a redirect.

---
 rtl/ifu_fetch_queue.sv | 200 ++++++++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue
//
// Instruction fetch unit: generates the PC, issues in-order requests to a
// variable-latency instruction memory, and buffers the returned instructions
// in a FIFO toward decode. A redirect (branch_taken) reloads the PC, flushes
// the queue and arranges for every response still in flight to be discarded.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   branch_taken       - redirect request, BranchPC is the new fetch target
//   imem_req_*         - request channel (valid/ready, addr = current PC)
//   imem_resp_*        - response channel (in order, no backpressure)
//   out_valid/ready    - queue head handshake toward decode
//   out_pc/instr/pc_4  - head PC, instruction and PC + 4 (all 0 when empty)
//   perf_fetched       - (IFU_FETCH_PERF_EN only) saturating dequeue count
//   perf_dropped       - (IFU_FETCH_PERF_EN only) saturating discard count
//
// Optional feature macro: IFU_FETCH_PERF_EN
// ---------------------------------------------------------------------------
module ifu_fetch_queue #(
    parameter int unsigned         PC_WIDTH        = 32,
    parameter int unsigned         INSTR_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'(32'h8000_0000),
    parameter int unsigned         FQ_DEPTH        = 4,
    parameter int unsigned         MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    BranchPC,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
`ifdef IFU_FETCH_PERF_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_dropped,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc_4
);

    localparam int unsigned AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [OW-1:0]       outstanding_q, outstanding_d;
    logic [OW-1:0]       drop_q, drop_d;
    logic [CW-1:0]       fq_count_q, fq_count_d;
    logic [AW-1:0]       fq_rd_ptr_q, fq_rd_ptr_d;
    logic [AW-1:0]       fq_wr_ptr_q, fq_wr_ptr_d;
    logic [PW-1:0]       pcf_rd_ptr_q, pcf_rd_ptr_d;
    logic [PW-1:0]       pcf_wr_ptr_q, pcf_wr_ptr_d;

    // Storage: addresses of in-flight requests, and the fetch queue itself.
    logic [PC_WIDTH-1:0]    pcf_q      [MAX_OUTSTANDING];
    logic [PC_WIDTH-1:0]    fq_pc_q    [FQ_DEPTH];
    logic [INSTR_WIDTH-1:0] fq_instr_q [FQ_DEPTH];

    logic req_fire;
    logic resp_fire;
    logic resp_keep;
    logic resp_drop;
    logic deq;

    // Credit counts queued entries plus requests in flight, so every response
    // already has a reserved slot when it arrives.
    assign imem_req_valid = !rst && !branch_taken
                          && (32'(outstanding_q) < MAX_OUTSTANDING)
                          && (32'(fq_count_q) + 32'(outstanding_q) < FQ_DEPTH);
    assign imem_req_addr  = pc_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation; it is
    // ignored so the counters cannot underflow.
    assign resp_fire = imem_resp_valid && !rst && (outstanding_q != '0);
    assign resp_keep = resp_fire && (drop_q == '0) && !branch_taken;
    assign resp_drop = resp_fire && !resp_keep;

    assign out_valid = !rst && (fq_count_q != '0);
    assign deq       = out_valid && out_ready && !branch_taken;

    assign out_pc    = out_valid ? fq_pc_q[fq_rd_ptr_q] : '0;
    assign out_instr = out_valid ? fq_instr_q[fq_rd_ptr_q] : '0;
    assign out_pc_4  = out_valid ? fq_pc_q[fq_rd_ptr_q] + PC_WIDTH'(4) : '0;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        fq_count_d    = fq_count_q;
        fq_rd_ptr_d   = fq_rd_ptr_q;
        fq_wr_ptr_d   = fq_wr_ptr_q;
        pcf_rd_ptr_d  = pcf_rd_ptr_q;
        pcf_wr_ptr_d  = pcf_wr_ptr_q;

        if (req_fire) begin
            pc_d         = pc_q + PC_WIDTH'(4);
            pcf_wr_ptr_d = (pcf_wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0
                                                                       : pcf_wr_ptr_q + PW'(1);
        end
        if (resp_fire) begin
            pcf_rd_ptr_d = (pcf_rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0
                                                                       : pcf_rd_ptr_q + PW'(1);
        end
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_fire);

        if (branch_taken) begin
            // Everything still in flight after this cycle belongs to the
            // wrong path; req_fire is 0 here, so that is outstanding minus
            // the response (if any) consumed now.
            pc_d        = BranchPC;
            drop_d      = outstanding_q - OW'(resp_fire);
            fq_count_d  = '0;
            fq_rd_ptr_d = '0;
            fq_wr_ptr_d = '0;
        end else begin
            if (resp_drop) begin
                drop_d = drop_q - OW'(1);
            end
            if (resp_keep) begin
                fq_wr_ptr_d = fq_wr_ptr_q + AW'(1);
            end
            if (deq) begin
                fq_rd_ptr_d = fq_rd_ptr_q + AW'(1);
            end
            fq_count_d = fq_count_q + CW'(resp_keep) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            fq_count_q    <= '0;
            fq_rd_ptr_q   <= '0;
            fq_wr_ptr_q   <= '0;
            pcf_rd_ptr_q  <= '0;
            pcf_wr_ptr_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fq_count_q    <= fq_count_d;
            fq_rd_ptr_q   <= fq_rd_ptr_d;
            fq_wr_ptr_q   <= fq_wr_ptr_d;
            pcf_rd_ptr_q  <= pcf_rd_ptr_d;
            pcf_wr_ptr_q  <= pcf_wr_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed behind the counters.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcf_q[pcf_wr_ptr_q] <= pc_q;
        end
        if (resp_keep) begin
            fq_pc_q[fq_wr_ptr_q]    <= pcf_q[pcf_rd_ptr_q];
            fq_instr_q[fq_wr_ptr_q] <= imem_resp_data;
        end
    end

`ifdef IFU_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_dropped_d = perf_dropped_q;
        if (deq && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (resp_drop && (perf_dropped_q != '1)) begin
            perf_dropped_d = perf_dropped_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_queue
//
// Self-checking bench for ifu_fetch_queue. A memory model answers the DUT's
// requests in order after a configurable or random latency. A queue-based
// reference model (in-flight list with stale marks, fetch-queue contents)
// predicts every output each cycle; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifu_fetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, branch_taken, imem_req_ready, imem_resp_valid, out_ready;
    logic [31:0] BranchPC, imem_resp_data;
    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_pc, out_instr, out_pc_4;
`ifdef IFU_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    ifu_fetch_queue #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC),
        .FQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .BranchPC(BranchPC),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
`ifdef IFU_FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_pc_4(out_pc_4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 1;
    bit lat_rand = 0;

    typedef struct { int due; logic [31:0] data; } mem_t;
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } fq_t;

    mem_t  mem_q[$];
    infl_t inflight[$];
    fq_t   fq[$];
    logic [31:0] m_pc = RST_PC;
    bit    pushed = 0;
    int    m_fetched = 0;
    int    m_dropped = 0;

    logic [31:0] req_log[$];
    logic [31:0] deq_log[$];
    logic        last_out_valid, last_req_valid;
    logic [31:0] last_req_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: present the memory response, compare all outputs
    // against the model at the falling edge, then advance model and memory.
    task automatic step();
        bit    exp_rv, exp_ov;
        infl_t e;
        if (rst) begin
            imem_resp_valid = 1'($urandom_range(0, 1));   // must be ignored
            imem_resp_data  = $urandom();
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom();
        end
        @(negedge clk);

        exp_rv = !rst && !branch_taken && (inflight.size() < MAXO)
                 && (fq.size() + inflight.size() < DEPTH);
        exp_ov = !rst && (fq.size() > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_pc", out_pc, fq[0].pc);
            chk("out_instr", out_instr, fq[0].instr);
            chk("out_pc_4", out_pc_4, fq[0].pc + 32'd4);
        end else if (!pushed) begin
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_instr", out_instr, 32'h0);
            chk("empty_pc_4", out_pc_4, 32'h0);
        end
`ifdef IFU_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_dropped", perf_dropped, 32'(m_dropped));
`endif
        if (imem_resp_valid && !rst) begin
            checks++;
            if (inflight.size() == 0) begin
                failures++;
                $display("FAIL resp_without_request cyc=%0d got=resp_valid want=no_response", cyc);
            end
        end

        last_out_valid = out_valid;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        if (out_valid && out_ready && !branch_taken) deq_log.push_back(out_pc);

        // memory environment
        if (imem_resp_valid && !rst && mem_q.size() > 0) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            mem_q.push_back('{cyc + (lat_rand ? int'($urandom_range(1, 4)) : mem_lat), $urandom()});
        end

        // reference model
        if (rst) begin
            m_pc = RST_PC;
            inflight.delete();
            fq.delete();
            mem_q.delete();
            pushed = 0;
            m_fetched = 0;
            m_dropped = 0;
        end else if (branch_taken) begin
            if (imem_resp_valid && inflight.size() > 0) begin
                void'(inflight.pop_front());
                m_dropped++;
            end
            fq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_pc = BranchPC;
        end else begin
            if (fq.size() > 0 && out_ready) begin
                void'(fq.pop_front());
                m_fetched++;
            end
            if (imem_resp_valid && inflight.size() > 0) begin
                e = inflight.pop_front();
                if (e.stale) m_dropped++;
                else begin
                    fq.push_back('{e.pc, imem_resp_data});
                    pushed = 1;
                end
            end
            if (exp_rv && imem_req_ready) begin
                inflight.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        branch_taken = 1'b0;
        step();
        step();
        rst = 1'b0;
        req_log.delete();
        deq_log.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int drop_before;

    initial begin
        rst = 1'b1; branch_taken = 1'b0; BranchPC = 32'h0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        out_ready = 1'b1;

        // 1: straight-line fetch, 1-cycle memory
        mem_lat = 1; lat_rand = 0;
        do_reset();
        run(12);
        chk("seq_req0", req_log[0], 32'h8000_0000);
        chk("seq_req1", req_log[1], 32'h8000_0004);
        chk("seq_req2", req_log[2], 32'h8000_0008);
        chk("seq_deq0", deq_log[0], 32'h8000_0000);
        chk("seq_deq1", deq_log[1], 32'h8000_0004);
        chk("seq_deq2", deq_log[2], 32'h8000_0008);

        // 2: decode stall fills the queue, then drains in order
        do_reset();
        out_ready = 1'b0;
        run(20);
        chk("stall_req_count", 32'(req_log.size()), 32'd4);
        chk("stall_model_occ", 32'(fq.size()), 32'd4);
        chk("stall_req_valid", 32'(last_req_valid), 32'd0);
        out_ready = 1'b1;
        run(12);
        for (int i = 0; i < 4; i++)
            chk("stall_drain", deq_log.size() > i ? deq_log[i] : 32'hDEAD_BEEF,
                32'h8000_0000 + 32'(4 * i));

        // 3: latency 3, redirect with two requests in flight
        mem_lat = 3;
        do_reset();
        run(2);
        drop_before = m_dropped;
        branch_taken = 1'b1; BranchPC = 32'h8000_0100;
        deq_log.delete();
        step();
        branch_taken = 1'b0;
        run(12);
        chk("redir_dropped", 32'(m_dropped - drop_before), 32'd2);
        chk("redir_first_pc", deq_log.size() > 0 ? deq_log[0] : 32'hDEAD_BEEF, 32'h8000_0100);
`ifdef IFU_FETCH_PERF_EN
        chk("redir_perf_dropped", perf_dropped, 32'd2);
`endif

        // 4: response coincides with the redirect
        mem_lat = 1;
        do_reset();
        step();
        drop_before = m_dropped;
        branch_taken = 1'b1; BranchPC = 32'h8000_0200;
        step();
        branch_taken = 1'b0;
        chk("same_cyc_dropped", 32'(m_dropped - drop_before), 32'd1);
        step();
        chk("same_cyc_empty", 32'(last_out_valid), 32'd0);
        chk("same_cyc_req_valid", 32'(last_req_valid), 32'd1);
        chk("same_cyc_req_addr", last_req_addr, 32'h8000_0200);

        // 5: fill, then random decode/memory pressure; order must be exact
        do_reset();
        out_ready = 1'b0;
        run(20);
        lat_rand = 1;
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            imem_req_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        chk("full_min_deq", 32'(deq_log.size() >= 8), 32'd1);
        foreach (deq_log[i]) chk("full_order", deq_log[i], 32'h8000_0000 + 32'(4 * i));
        imem_req_ready = 1'b1; out_ready = 1'b1; lat_rand = 0;

        // 6: PC wrap at the top of the address space
        do_reset();
        step();
        branch_taken = 1'b1; BranchPC = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        req_log.delete();
        run(6);
        chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        chk("wrap_req1", req_log[1], 32'h0000_0000);
        chk("wrap_req2", req_log[2], 32'h0000_0004);

        // 7: random traffic with redirects and occasional reset
        lat_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 999) < 3);
            branch_taken = ($urandom_range(0, 99) < 5);
            BranchPC = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            imem_req_ready = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        rst = 1'b0; branch_taken = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
